// File: rtl/hyperbus_pkg.sv
// Shared types and command/address helpers for the HyperBus transaction sequencer.
package hyperbus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CA,
    S_LAT,
    S_WDATA,
    S_RDATA,
    S_CSHOLD
  } state_t;

  localparam int unsigned CA_RW = 47;
  localparam int unsigned CA_AS = 46;
  localparam int unsigned CA_BT = 45;

  // 48-bit command/address word: linear burst, half-word address split across
  // the upper row field and the low column bits.
  function automatic logic [47:0] build_ca(input logic we, input logic is_reg,
                                           input logic [31:0] addr);
    logic [47:0] ca;
    ca          = '0;
    ca[CA_RW]   = ~we;
    ca[CA_AS]   = is_reg;
    ca[CA_BT]   = 1'b1;
    ca[44:16]   = addr[31:3];
    ca[2:0]     = addr[2:0];
    return ca;
  endfunction

endpackage

// File: rtl/hyperbus_seq.sv
// HyperBus transaction sequencer: turns host word requests into CS#/CK/CA/latency/data
// phases for the 8-bit DDR I/O cell and returns captured read words.
module hyperbus_seq
  import hyperbus_pkg::*;
#(
  parameter int unsigned LAT     = 6,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned CSHI    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic             req_reg,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [15:0]      wdat,
  input  logic             wdat_valid,
  output logic             wdat_ready,
  output logic [15:0]      rdat,
  output logic             rdat_valid,
  output logic             done,
  output logic             err,
  output logic             cs_n,
  output logic             ck_en,
  output logic             dq_oe,
  output logic [15:0]      dq_o,
  input  logic [15:0]      dq_i,
  input  logic             rwds_i,
  output logic             rwds_oe,
  output logic             rwds_o
);

  localparam int unsigned LAT_W = $clog2(2*LAT+1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT+1);
  localparam int unsigned HLD_W = $clog2(CSHI+1);

  state_t             r_state;
  state_t             w_next;
  logic               r_we;
  logic               r_reg;
  logic [47:0]        r_ca;
  logic               r_lat2;
  logic [1:0]         r_beat;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [LEN_W-1:0]   r_words;
  logic [TMO_W-1:0]   r_timer;
  logic [HLD_W-1:0]   r_hold;
  logic               r_err;
  logic [15:0]        r_rdat;
  logic               r_rdat_valid;
  logic               w_timeout;
  logic               w_first_hold;

  assign w_timeout    = (r_timer == TMO_W'(TIMEOUT-1));
  assign w_first_hold = (r_state == S_CSHOLD) && (r_hold == HLD_W'(CSHI-1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = S_CA;
      S_CA:     if (r_beat == 2'd2) w_next = (r_we && r_reg) ? S_WDATA : S_LAT;
      S_LAT:    if (r_lat_cnt == '0) w_next = r_we ? S_WDATA : S_RDATA;
      S_WDATA:  if (wdat_valid && r_words == LEN_W'(1)) w_next = S_CSHOLD;
      S_RDATA: begin
        if (rwds_i) begin
          if (r_words == LEN_W'(1)) w_next = S_CSHOLD;
        end else if (w_timeout) begin
          w_next = S_CSHOLD;
        end
      end
      S_CSHOLD: if (r_hold == '0) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    wdat_ready = 1'b0;
    cs_n       = 1'b1;
    ck_en      = 1'b0;
    dq_oe      = 1'b0;
    dq_o       = '0;
    rwds_oe    = 1'b0;
    rwds_o     = 1'b0;
    done       = w_first_hold;
    err        = w_first_hold & r_err;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_CA: begin
        cs_n  = 1'b0;
        ck_en = 1'b1;
        dq_oe = 1'b1;
        // Low byte leaves on the rising edge, so each beat is byte-swapped.
        case (r_beat)
          2'd0:    dq_o = {r_ca[39:32], r_ca[47:40]};
          2'd1:    dq_o = {r_ca[23:16], r_ca[31:24]};
          default: dq_o = {r_ca[7:0],   r_ca[15:8]};
        endcase
      end
      S_LAT, S_RDATA: begin
        cs_n  = 1'b0;
        ck_en = 1'b1;
      end
      S_WDATA: begin
        cs_n       = 1'b0;
        ck_en      = 1'b1;
        dq_oe      = 1'b1;
        dq_o       = {wdat[7:0], wdat[15:8]};
        wdat_ready = wdat_valid;
        rwds_oe    = ~r_reg;
        rwds_o     = ~r_reg & ~wdat_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_reg        <= 1'b0;
      r_ca         <= '0;
      r_lat2       <= 1'b0;
      r_beat       <= '0;
      r_lat_cnt    <= '0;
      r_words      <= '0;
      r_timer      <= '0;
      r_hold       <= '0;
      r_err        <= 1'b0;
      r_rdat       <= '0;
      r_rdat_valid <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_rdat_valid <= 1'b0;
      if (w_next == S_CSHOLD && r_state != S_CSHOLD)
        r_hold <= HLD_W'(CSHI-1);
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_reg   <= req_reg;
            r_ca    <= build_ca(req_we, req_reg, req_addr);
            r_beat  <= '0;
            r_lat2  <= 1'b0;
            r_err   <= 1'b0;
            // Register writes carry exactly one word regardless of req_len.
            r_words <= (req_we && req_reg) ? LEN_W'(1)
                     : ((req_len == '0) ? LEN_W'(1) : req_len);
          end
        end
        S_CA: begin
          r_beat  <= r_beat + 2'd1;
          r_timer <= '0;
          if (r_beat == 2'd0) r_lat2 <= rwds_i;
          if (r_beat == 2'd2)
            r_lat_cnt <= r_lat2 ? LAT_W'(2*LAT-1) : LAT_W'(LAT-1);
        end
        S_LAT: begin
          if (r_lat_cnt != '0) r_lat_cnt <= r_lat_cnt - LAT_W'(1);
        end
        S_WDATA: begin
          if (wdat_valid) r_words <= r_words - LEN_W'(1);
        end
        S_RDATA: begin
          if (rwds_i) begin
            r_rdat       <= dq_i;
            r_rdat_valid <= 1'b1;
            r_words      <= r_words - LEN_W'(1);
            r_timer      <= '0;
          end else begin
            r_timer <= r_timer + TMO_W'(1);
            if (w_timeout) r_err <= 1'b1;
          end
        end
        S_CSHOLD: begin
          if (r_hold != '0) r_hold <= r_hold - HLD_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rdat       = r_rdat;
  assign rdat_valid = r_rdat_valid;

endmodule
